// File: rtl/n64adv2_rst_sequencer.sv
// -----------------------------------------------------------------------------
// n64adv2_rst_sequencer
//
// Central reset sequencer for NUM_CH reset domains that share CLK_i. After
// power-on it waits BOOT_DELAY clock-enabled cycles and then waits for PLL lock.
// It then releases the channel resets one by one, STEP_DELAY cycles apart.
// On PLL lock loss it re-asserts every channel. On a soft reset request it
// re-asserts only the unmasked channels. Each re-assertion lasts at least
// RST_LEN cycles.
//
// Ports:
//   CLK_i         sequencer clock
//   nRST_i        asynchronous active-low power-on reset of the whole block
//   clk_en_i      qualifies boot-delay counting only
//   pll_locked_i  asynchronous PLL lock, synchronised here (2 FF)
//   soft_nrst_i   asynchronous active-low soft reset request, synchronised here
//   mask_i        per channel: 1 = ignore soft reset (lock loss still resets)
//   nRST_o        registered active-low channel resets
//   seq_done_o    high only in RUN
//   state_o       current state (BOOT=0, LOCK=1, REL=2, RUN=3, HOLD=4)
// -----------------------------------------------------------------------------
module n64adv2_rst_sequencer #(
   parameter int NUM_CH     = 4,
   parameter int BOOT_DELAY = 255,
   parameter int STEP_DELAY = 16,
   parameter int RST_LEN    = 4
) (
   input  logic              CLK_i,
   input  logic              nRST_i,
   input  logic              clk_en_i,
   input  logic              pll_locked_i,
   input  logic              soft_nrst_i,
   input  logic [NUM_CH-1:0] mask_i,
   output logic [NUM_CH-1:0] nRST_o,
   output logic              seq_done_o,
   output logic [2:0]        state_o
);

   localparam int BOOT_W = $clog2(BOOT_DELAY + 1);
   localparam int STEP_W = $clog2(STEP_DELAY + 1);
   localparam int HOLD_W = $clog2(RST_LEN + 1);
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DELAY - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_LEN);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      ST_BOOT = 3'd0,
      ST_LOCK = 3'd1,
      ST_REL  = 3'd2,
      ST_RUN  = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                rel_done_q, rel_done_d;
   logic [NUM_CH-1:0]   rst_q, rst_d;

   // ---- synchroniser stage: async inputs -> p0 -> p1 ----
   logic lock_sync_p0, lock_sync_p1;
   logic soft_sync_p0, soft_sync_p1;

   always_ff @(posedge CLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         lock_sync_p0 <= 1'b0;
         lock_sync_p1 <= 1'b0;
         soft_sync_p0 <= 1'b0;
         soft_sync_p1 <= 1'b0;
      end else begin
         lock_sync_p0 <= pll_locked_i;
         lock_sync_p1 <= lock_sync_p0;
         soft_sync_p0 <= soft_nrst_i;
         soft_sync_p1 <= soft_sync_p0;
      end
   end

   // ---- sequencer state register ----
   always_ff @(posedge CLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= '0;
         step_cnt_q <= '0;
         hold_cnt_q <= '0;
         idx_q      <= '0;
         rel_done_q <= 1'b0;
         rst_q      <= '0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         step_cnt_q <= step_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         idx_q      <= idx_d;
         rel_done_q <= rel_done_d;
         rst_q      <= rst_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      step_cnt_d = step_cnt_q;
      hold_cnt_d = hold_cnt_q;
      idx_d      = idx_q;
      rel_done_d = rel_done_q;
      rst_d      = rst_q;

      case (state_q)
         ST_BOOT: begin
            if (clk_en_i) begin
               if (boot_cnt_q == BOOT_LAST) begin
                  boot_cnt_d = '0;
                  state_d    = ST_LOCK;
               end else begin
                  boot_cnt_d = boot_cnt_q + BOOT_W'(1);
               end
            end
         end

         ST_LOCK: begin
            // Keep the release bookkeeping cleared while waiting, so REL
            // always starts at channel 0 with a fresh step count.
            step_cnt_d = '0;
            idx_d      = '0;
            rel_done_d = 1'b0;
            if (lock_sync_p1 && soft_sync_p1)
               state_d = ST_REL;
         end

         ST_REL, ST_RUN: begin
            if (!lock_sync_p1) begin
               rst_d      = '0;
               hold_cnt_d = '0;
               state_d    = ST_HOLD;
            end else if (!soft_sync_p1) begin
               // Masked channels keep whatever value they currently have.
               rst_d      = rst_q & mask_i;
               hold_cnt_d = '0;
               state_d    = ST_HOLD;
            end else if (state_q == ST_REL) begin
               if (rel_done_q) begin
                  state_d = ST_RUN;
               end else if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  for (int k = 0; k < NUM_CH; k++)
                     if (idx_q == IDX_W'(k))
                        rst_d[k] = 1'b1;
                  if (idx_q == IDX_LAST)
                     rel_done_d = 1'b1;
                  else
                     idx_d = idx_q + IDX_W'(1);
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
            end
         end

         ST_HOLD: begin
            if (!lock_sync_p1) begin
               // Ongoing lock loss keeps every channel asserted and keeps
               // restarting the minimum assertion time.
               rst_d      = '0;
               hold_cnt_d = '0;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else if (soft_sync_p1) begin
               state_d = ST_LOCK;
            end
         end

         default: state_d = ST_BOOT;
      endcase
   end

   assign nRST_o     = rst_q;
   assign seq_done_o = (state_q == ST_RUN);
   assign state_o    = state_q;

endmodule
